// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480 @ 60 Hz; the derived values match those defaults.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // Half-open window test [lo, hi), unsigned.
  function automatic logic in_window(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to its consumers.
// Consumers sample h_cnt/v_cnt/valid only in cycles where pclk_en is high.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic             pclk_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hsync;
  logic             vsync;
  logic             valid;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pclk_en, h_cnt, v_cnt, hsync, vsync, valid, line_start, frame_start
  );

  modport slave (
    input pclk_en, h_cnt, v_cnt, hsync, vsync, valid, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen_pclk_divider.sv
// Pixel-rate strobe: one clk high out of every CLK_DIV system clocks.
// The strobe is registered so it is high exactly while div reads CLK_DIV-1.
module pclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pclk_en
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = (div == LAST) ? '0 : div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      pclk_en <= 1'b0;
    end else begin
      div     <= div_next;
      pclk_en <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, h/v counters, syncs, active-video and start pulses.
// Every output is registered from next-state values so all of them line up with h_cnt/v_cnt.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = 0
) (
  input  logic clk,
  input  logic rst,
  vga_timing_if.master vif
);

  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic             ACT    = 1'(SYNC_POL);

  logic             pclk_en;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_next, v_next;
  logic             h_wrap, v_wrap;
  logic             hsync, vsync, valid, line_start, frame_start;

  pclk_divider #(.CLK_DIV(CLK_DIV)) u_pclk_divider (
    .clk     (clk),
    .rst     (rst),
    .pclk_en (pclk_en)
  );

  always_comb begin
    h_wrap = pclk_en && (h_cnt == H_LAST);
    v_wrap = h_wrap && (v_cnt == V_LAST);
    h_next = h_cnt;
    v_next = v_cnt;
    if (pclk_en) begin
      h_next = h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) begin
        v_next = v_wrap ? '0 : v_cnt + CNT_W'(1);
      end
    end
  end

  // Decoding from h_next/v_next keeps syncs and valid aligned with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~ACT;
      vsync       <= ~ACT;
      valid       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= in_window(h_next, HS_LO, HS_HI) ? ACT : ~ACT;
      vsync       <= in_window(v_next, VS_LO, VS_HI) ? ACT : ~ACT;
      valid       <= (h_next < H_VIS) && (v_next < V_VIS);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

  assign vif.pclk_en     = pclk_en;
  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.hsync       = hsync;
  assign vif.vsync       = vsync;
  assign vif.valid       = valid;
  assign vif.line_start  = line_start;
  assign vif.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance checked against hand-computed vectors,
// two tiny-raster instances (both sync polarities) checked every cycle against a raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vif0 ();
  vga_timing_if vif1 ();
  vga_timing_if vif2 ();

  vga_timing_gen u_dflt (
    .clk (clk),
    .rst (rst),
    .vif (vif0)
  );

  // Tiny raster: H_TOTAL=15 (hsync 10..12), V_TOTAL=9 (vsync 5..6), 2 clks/pixel, frame=270 clks.
  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(0)
  ) u_lo (
    .clk (clk),
    .rst (rst),
    .vif (vif1)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1)
  ) u_hi (
    .clk (clk),
    .rst (rst),
    .vif (vif2)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [9:0] h;
    logic [9:0] v;
    logic       pen, hs, vs, val, ls, fs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pack_out(input logic [9:0] h, input logic [9:0] v,
                                           input logic pen, input logic hs, input logic vs,
                                           input logic val, input logic ls, input logic fs);
    return {6'b0, h, v, pen, hs, vs, val, ls, fs};
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  task automatic add_vec(input int cyc, input int h, input int v, input logic pen,
                         input logic hs, input logic vs, input logic val,
                         input logic ls, input logic fs);
    vec_t e;
    e.cyc = cyc; e.h = 10'(h); e.v = 10'(v);
    e.pen = pen; e.hs = hs; e.vs = vs; e.val = val; e.ls = ls; e.fs = fs;
    tbl.push_back(e);
  endtask

  // Default instance: apply every table entry whose cycle index matches.
  task automatic dflt_table_check(input int c);
    foreach (tbl[i]) begin
      if (tbl[i].cyc == c) begin
        check("dflt_vec", c,
              pack_out(vif0.h_cnt, vif0.v_cnt, vif0.pclk_en, vif0.hsync, vif0.vsync,
                       vif0.valid, vif0.line_start, vif0.frame_start),
              pack_out(tbl[i].h, tbl[i].v, tbl[i].pen, tbl[i].hs, tbl[i].vs,
                       tbl[i].val, tbl[i].ls, tbl[i].fs));
      end
    end
  endtask

  // Raster model for the tiny instances, c = clks since reset release.
  task automatic small_check(input int c);
    int pix, h, v;
    logic pen, hsa, vsa, val, ls, fs;
    pix = c / 2;
    h   = pix % 15;
    v   = (pix / 15) % 9;
    pen = (c % 2) == 1;
    hsa = (h >= 10) && (h < 13);
    vsa = (v >= 5) && (v < 7);
    val = (h < 8) && (v < 4);
    ls  = (c != 0) && (c % 30 == 0);
    fs  = (c != 0) && (c % 270 == 0);
    check("lo_pol", c,
          pack_out(vif1.h_cnt, vif1.v_cnt, vif1.pclk_en, vif1.hsync, vif1.vsync,
                   vif1.valid, vif1.line_start, vif1.frame_start),
          pack_out(10'(h), 10'(v), pen, ~hsa, ~vsa, val, ls, fs));
    check("hi_pol", c,
          pack_out(vif2.h_cnt, vif2.v_cnt, vif2.pclk_en, vif2.hsync, vif2.vsync,
                   vif2.valid, vif2.line_start, vif2.frame_start),
          pack_out(10'(h), 10'(v), pen, hsa, vsa, val, ls, fs));
  endtask

  // ---------------- driver ----------------
  task automatic apply_reset();
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- test ----------------
  int hs_clks, hs_first_h, ls_count, ls_cyc, val_viol;
  int vs_clks, vs_first, vis_pix, fs_first, fs_second;

  initial begin
    //        cyc   h    v  pen hs vs val ls fs
    add_vec(   0,   0,   0, 0, 1, 1, 1, 0, 0);
    add_vec(   2,   0,   0, 0, 1, 1, 1, 0, 0);
    add_vec(   3,   0,   0, 1, 1, 1, 1, 0, 0);
    add_vec(   4,   1,   0, 0, 1, 1, 1, 0, 0);
    add_vec(   7,   1,   0, 1, 1, 1, 1, 0, 0);
    add_vec(   8,   2,   0, 0, 1, 1, 1, 0, 0);
    add_vec(2559, 639,   0, 1, 1, 1, 1, 0, 0);
    add_vec(2560, 640,   0, 0, 1, 1, 0, 0, 0);
    add_vec(2623, 655,   0, 1, 1, 1, 0, 0, 0);
    add_vec(2624, 656,   0, 0, 0, 1, 0, 0, 0);
    add_vec(3007, 751,   0, 1, 0, 1, 0, 0, 0);
    add_vec(3008, 752,   0, 0, 1, 1, 0, 0, 0);
    add_vec(3199, 799,   0, 1, 1, 1, 0, 0, 0);
    add_vec(3200,   0,   1, 0, 1, 1, 1, 1, 0);
    add_vec(3201,   0,   1, 0, 1, 1, 1, 0, 0);
    add_vec(3203,   0,   1, 1, 1, 1, 1, 0, 0);

    hs_clks = 0; hs_first_h = -1; ls_count = 0; ls_cyc = -1; val_viol = 0;
    vs_clks = 0; vs_first = -1; vis_pix = 0; fs_first = -1; fs_second = -1;

    apply_reset();

    // Phase 1: one full default line plus twelve tiny frames.
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      dflt_table_check(c);
      small_check(c);
      if (c < 3200 && vif0.hsync == 1'b0) begin
        hs_clks++;
        if (hs_first_h < 0) hs_first_h = int'(vif0.h_cnt);
      end
      if (vif0.line_start) begin
        ls_count++;
        if (ls_cyc < 0) ls_cyc = c;
      end
      if (vif0.valid && (vif0.h_cnt >= 10'd640 || vif0.v_cnt >= 10'd480)) val_viol++;
      if (c < 270) begin
        if (vif1.vsync == 1'b0) begin
          vs_clks++;
          if (vs_first < 0) vs_first = int'({vif1.v_cnt, vif1.h_cnt});
        end
        if (vif1.pclk_en && vif1.valid) vis_pix++;
      end
      if (vif1.frame_start) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
    end

    check("hsync_width", 0, 32'(hs_clks), 32'd384);
    check("hsync_first_h", 0, 32'(hs_first_h), 32'd656);
    check("line_start_count", 0, 32'(ls_count), 32'd1);
    check("line_start_cyc", 0, 32'(ls_cyc), 32'd3200);
    check("valid_outside", 0, 32'(val_viol), 32'd0);
    check("vsync_width", 0, 32'(vs_clks), 32'd60);
    check("vsync_first_vh", 0, 32'(vs_first), 32'((5 << 10) | 0));
    check("visible_pixels", 0, 32'(vis_pix), 32'd32);
    check("frame_interval", 0, 32'(fs_second - fs_first), 32'd270);

    // Phase 2: run on to a point inside both tiny syncs (h=11, v=5), then reset for one clk.
    for (int c = 3300; c < 3600; c++) begin
      @(negedge clk);
      small_check(c);
      if (c % 270 == 172) begin
        check("pre_rst_pos", c, {12'b0, vif1.v_cnt, vif1.h_cnt}, {12'b0, 10'd5, 10'd11});
        rst = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Phase 3: timing restarts exactly as after the first reset.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      dflt_table_check(c);
      small_check(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. Produces a 25 MHz pixel-enable strobe, horizontal/vertical pixel counters, sync pulses, an active-video flag and line/frame start pulses. Sits directly upstream of the canvas address generator and the pixel colour mux, and drives the board VGA connector sync pins.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel; must be ≥ 2.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level; 0 = active-low.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- pclk_en  out  1  one-clk strobe, once every CLK_DIV clks.
- h_cnt  out  10  pixel column, 0..H_TOTAL-1 (H_TOTAL = 800).
- v_cnt  out  10  line, 0..V_TOTAL-1 (V_TOTAL = 525).
- hsync  out  1  horizontal sync, level per SYNC_POL.
- vsync  out  1  vertical sync, level per SYNC_POL.
- valid  out  1  high when h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
- line_start  out  1  one-clk pulse when h_cnt wraps to 0.
- frame_start  out  1  one-clk pulse when h_cnt and v_cnt both wrap to 0.

## Operation

- Divider: div counts 0..CLK_DIV-1 every clk and wraps to 0. pclk_en = 1 in the cycle in which div = CLK_DIV-1.
- Horizontal counter: on pclk_en, h_cnt increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: on pclk_en with h_cnt = H_TOTAL-1, v_cnt increments. At V_TOTAL-1 it wraps to 0.
- hsync is active for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), i.e. [656, 752).
- vsync is active for v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC), i.e. [490, 492).
- Inactive sync level = ~SYNC_POL.
- All outputs are registered. hsync, vsync and valid are decoded from the *next* counter values, so every output is a pure function of the h_cnt/v_cnt presented in the same cycle (zero skew).
- line_start and frame_start are registered from the wrap condition. They assert in the same cycle that h_cnt (and v_cnt) reads 0 and last exactly one clk.
- Counter widths: the 10-bit counters hold 799/524 without overflow. Comparisons are unsigned.

## Timing

- Reset values: div=0, pclk_en=0, h_cnt=0, v_cnt=0, hsync=vsync=inactive, valid=1, line_start=0, frame_start=0.
- First pclk_en occurs CLK_DIV clks after rst deasserts (cycle CLK_DIV-1, counting from 0).
- First counter advance, to h_cnt=1, is visible the cycle after that strobe.
- Each (h_cnt, v_cnt) value is held for exactly CLK_DIV clks. Line = 3200 clks; frame = 1,680,000 clks.
- rst asserted mid-frame: on the next clk edge, all state returns to its reset values regardless of position. No partial sync pulse is extended.
- Simultaneous h-wrap and v-wrap raise line_start and frame_start in the same cycle.
- valid goes low in the cycle h_cnt becomes 640 and high again in the cycle h_cnt becomes 0 on a visible line.
- Downstream consumers sample h_cnt/v_cnt/valid only when pclk_en=1.

## Structure

- Package vga_timing_pkg:
  - default timing constants (640/16/96/48, 480/10/2/33).
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - counter width 10.
- Sub-module pclk_divider: parameter CLK_DIV, inputs clk/rst, output pclk_en.
- The raster counters and decode remain in vga_timing_gen.

## Test plan

- Reset release → pclk_en first high at clk 3 after release, then every 4 clks. h_cnt=1 at clk 4.
- Run one line → hsync active exactly 96×4 = 384 clks, first active with h_cnt=656. line_start pulses once per 3200 clks.
- Run one frame → vsync active for 2 lines (6400 clks) starting at v_cnt=490, h_cnt=0. frame_start interval = 1,680,000 clks.
- Count pclk_en cycles with valid=1 over one frame → exactly 307,200. valid never high with h_cnt ≥ 640 or v_cnt ≥ 480.
- Assert rst for one clk at h_cnt=700, v_cnt=491 (inside both syncs) → next cycle h_cnt=0, v_cnt=0, hsync=vsync=1, valid=1. Timing restarts as after the first reset.
- Override SYNC_POL=1 → hsync/vsync idle low and pulse high over the same windows as the default case.
